// File: rtl/async_fifo_v2_pkg.sv
// Shared helpers for the dual-clock FIFO: gray-code conversion and parameter legality.
`timescale 1ns/100ps
package async_fifo_v2_pkg;

   localparam int MAX_ADDR_W = 12;
   localparam int PTR_W_MAX  = MAX_ADDR_W + 1;

   function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Zero-extended inputs decode correctly because the unused MSBs stay 0.
   function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
      logic [PTR_W_MAX-1:0] b;
      b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
      for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic bit params_legal(input int aw, input int ss, input int fwft,
                                       input int af, input int ae);
      int depth;
      depth = 1 << aw;
      return (aw >= 2) && (aw <= MAX_ADDR_W) && (ss >= 2) && (fwft == 0 || fwft == 1) &&
             (af >= 0) && (af <= depth) && (ae >= 0) && (ae < depth);
   endfunction

endpackage

// File: rtl/async_fifo_v2_dpram.sv
// Simple dual-port RAM: write port on wclk, registered read port on rclk with read enable.
`timescale 1ns/100ps
module async_fifo_v2_dpram
   import async_fifo_v2_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          wclk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          rclk,
   input  logic          rrst_n,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [1 << AW];
   logic [DW-1:0] rdata_q, rdata_d;

   always_ff @(posedge wclk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   // Output register holds its value between reads; it doubles as the FWFT head stage.
   always_comb begin
      rdata_d = re ? mem_q[raddr] : rdata_q;
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) rdata_q <= '0;
      else         rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/async_fifo_v2_sync.sv
// Multi-flop synchroniser, cleared asynchronously; also used as a reset-release synchroniser.
`timescale 1ns/100ps
module async_fifo_v2_sync
   import async_fifo_v2_pkg::*;
#(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync_q [STAGES];
   logic [WIDTH-1:0] sync_d [STAGES];

   always_comb begin
      sync_d[0] = d;
      for (int i = 1; i < STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '{default: '0};
      else        sync_q <= sync_d;
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_v2.sv
// Dual-clock FIFO with gray-pointer CDC, threshold flags, sticky errors and optional FWFT read.
`timescale 1ns/100ps
module async_fifo_v2
   import async_fifo_v2_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FWFT        = 0,
   parameter int AF_THRESH   = (1 << ADDR_WIDTH) - 2,
   parameter int AE_THRESH   = 2
) (
   input  logic                  rst_n,
   input  logic                  clk_write,
   input  logic                  clk_read,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  almost_full,
   output logic                  overflow,
   output logic [ADDR_WIDTH:0]   wr_count,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  empty,
   output logic                  almost_empty,
   output logic                  underflow,
   output logic [ADDR_WIDTH:0]   rd_count
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(1 << ADDR_WIDTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   if (!params_legal(ADDR_WIDTH, SYNC_STAGES, FWFT, AF_THRESH, AE_THRESH)) begin : g_bad_params
      $fatal(1, "async_fifo_v2: illegal parameter combination");
   end

   function automatic logic [CW-1:0] to_gray(input logic [CW-1:0] b);
      return CW'(bin2gray(PTR_W_MAX'(b)));
   endfunction

   function automatic logic [CW-1:0] from_gray(input logic [CW-1:0] g);
      return CW'(gray2bin(PTR_W_MAX'(g)));
   endfunction

   logic wr_rst_n, rd_rst_n;

   async_fifo_v2_sync #(.WIDTH(1), .STAGES(2)) u_wr_rst_sync (
      .clk(clk_write), .rst_n(rst_n), .d(1'b1), .q(wr_rst_n));
   async_fifo_v2_sync #(.WIDTH(1), .STAGES(2)) u_rd_rst_sync (
      .clk(clk_read), .rst_n(rst_n), .d(1'b1), .q(rd_rst_n));

   // ---------------- write domain ----------------
   logic [CW-1:0] wptr_bin_q, wptr_bin_d, wptr_gray_q, wptr_gray_d;
   logic [CW-1:0] rptr_gray_ws, rptr_bin_ws, wr_count_q, wr_count_d;
   logic          full_q, full_d, almost_full_q, almost_full_d, overflow_q, overflow_d;
   logic          wr_accept;

   always_comb begin
      wr_accept     = wr_en && !full_q;
      wptr_bin_d    = wptr_bin_q + CW'(wr_accept);
      wptr_gray_d   = to_gray(wptr_bin_d);
      rptr_bin_ws   = from_gray(rptr_gray_ws);
      wr_count_d    = wptr_bin_d - rptr_bin_ws;
      full_d        = (wr_count_d == DEPTH_C);
      almost_full_d = (wr_count_d >= AF_C);
      overflow_d    = overflow_q || (wr_en && full_q);
   end

   always_ff @(posedge clk_write or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         wptr_bin_q    <= '0;
         wptr_gray_q   <= '0;
         wr_count_q    <= '0;
         full_q        <= 1'b0;
         almost_full_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         wptr_bin_q    <= wptr_bin_d;
         wptr_gray_q   <= wptr_gray_d;
         wr_count_q    <= wr_count_d;
         full_q        <= full_d;
         almost_full_q <= almost_full_d;
         overflow_q    <= overflow_d;
      end
   end

   // ---------------- read domain ----------------
   logic [CW-1:0] rptr_bin_q, rptr_bin_d, rptr_gray_q, rptr_gray_d;
   logic [CW-1:0] wptr_gray_rs, wptr_bin_rs, mem_cnt_q, mem_cnt_d, rd_count_q, rd_count_d;
   logic          rd_valid_q, rd_valid_d, empty_q, empty_d;
   logic          almost_empty_q, almost_empty_d, underflow_q, underflow_d;
   logic          ram_re, mem_avail;

   assign mem_avail = (mem_cnt_q != '0);

   // FWFT keeps the RAM output register filled whenever a word is available in memory.
   if (FWFT != 0) begin : g_fwft
      always_comb begin
         ram_re     = mem_avail && (!rd_valid_q || rd_en);
         rd_valid_d = ram_re || (rd_valid_q && !rd_en);
      end
   end else begin : g_std
      always_comb begin
         ram_re     = rd_en && mem_avail;
         rd_valid_d = ram_re;
      end
   end

   always_comb begin
      rptr_bin_d     = rptr_bin_q + CW'(ram_re);
      rptr_gray_d    = to_gray(rptr_bin_d);
      wptr_bin_rs    = from_gray(wptr_gray_rs);
      mem_cnt_d      = wptr_bin_rs - rptr_bin_d;
      rd_count_d     = mem_cnt_d + ((FWFT != 0) ? CW'(rd_valid_d) : '0);
      empty_d        = (FWFT != 0) ? !rd_valid_d : (mem_cnt_d == '0);
      almost_empty_d = (rd_count_d <= AE_C);
      underflow_d    = underflow_q || (rd_en && empty_q);
   end

   always_ff @(posedge clk_read or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         rptr_bin_q     <= '0;
         rptr_gray_q    <= '0;
         mem_cnt_q      <= '0;
         rd_count_q     <= '0;
         rd_valid_q     <= 1'b0;
         empty_q        <= 1'b1;
         almost_empty_q <= 1'b1;
         underflow_q    <= 1'b0;
      end else begin
         rptr_bin_q     <= rptr_bin_d;
         rptr_gray_q    <= rptr_gray_d;
         mem_cnt_q      <= mem_cnt_d;
         rd_count_q     <= rd_count_d;
         rd_valid_q     <= rd_valid_d;
         empty_q        <= empty_d;
         almost_empty_q <= almost_empty_d;
         underflow_q    <= underflow_d;
      end
   end

   // ---------------- crossings and storage ----------------
   async_fifo_v2_sync #(.WIDTH(CW), .STAGES(SYNC_STAGES)) u_rptr_sync (
      .clk(clk_write), .rst_n(wr_rst_n), .d(rptr_gray_q), .q(rptr_gray_ws));
   async_fifo_v2_sync #(.WIDTH(CW), .STAGES(SYNC_STAGES)) u_wptr_sync (
      .clk(clk_read), .rst_n(rd_rst_n), .d(wptr_gray_q), .q(wptr_gray_rs));

   async_fifo_v2_dpram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_ram (
      .wclk  (clk_write),
      .we    (wr_accept),
      .waddr (wptr_bin_q[ADDR_WIDTH-1:0]),
      .wdata (wr_data),
      .rclk  (clk_read),
      .rrst_n(rd_rst_n),
      .re    (ram_re),
      .raddr (rptr_bin_q[ADDR_WIDTH-1:0]),
      .rdata (rd_data)
   );

   assign full         = full_q;
   assign almost_full  = almost_full_q;
   assign overflow     = overflow_q;
   assign wr_count     = wr_count_q;
   assign rd_valid     = rd_valid_q;
   assign empty        = empty_q;
   assign almost_empty = almost_empty_q;
   assign underflow    = underflow_q;
   assign rd_count     = rd_count_q;

endmodule
